// File: rtl/ldm_writeback_seq.sv
// Load-multiple writeback sequencer: drains a load-data stream into the register
// file in ascending register order, then optionally writes the updated base register.
`timescale 1ns/1ps
module ldm_writeback_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] reglist,
    input  logic [3:0]  base_reg,
    input  logic        wb_en,
    input  logic [31:0] wb_data,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        busy,
    output logic        done,
    output logic        write,
    output logic [3:0]  write_reg,
    output logic [31:0] write_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] BASE = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    logic [1:0]  state_r;
    logic [15:0] mask_r;
    logic [3:0]  base_r;
    logic [31:0] wb_data_r;
    logic        wb_eff_r;

    logic        wb_eff_s;
    logic [3:0]  low_idx_s;
    logic [15:0] mask_clr_s;

    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Next-request decode and lowest-pending-register selection.
    always_comb begin
        wb_eff_s   = wb_en && !reglist[base_reg];
        low_idx_s  = lowest_set(mask_r);
        mask_clr_s = mask_r & (mask_r - 16'd1);
    end

    assign ld_ready = (state_r == XFER);
    assign busy     = (state_r != IDLE);
    assign done     = (state_r == FIN);

    // Sequencer state, latched request and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            mask_r     <= 16'd0;
            base_r     <= 4'd0;
            wb_data_r  <= 32'd0;
            wb_eff_r   <= 1'b0;
            write      <= 1'b0;
            write_reg  <= 4'd0;
            write_data <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    write <= 1'b0;
                    if (start) begin
                        mask_r    <= reglist;
                        base_r    <= base_reg;
                        wb_data_r <= wb_data;
                        wb_eff_r  <= wb_eff_s;
                        if (reglist != 16'd0) begin
                            state_r <= XFER;
                        end else if (wb_eff_s) begin
                            state_r <= BASE;
                        end else begin
                            state_r <= FIN;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                XFER: begin
                    if (ld_valid) begin
                        write      <= 1'b1;
                        write_reg  <= low_idx_s;
                        write_data <= ld_data;
                        mask_r     <= mask_clr_s;
                        // Last pending register consumed: leave the transfer phase.
                        if (mask_clr_s == 16'd0) begin
                            state_r <= wb_eff_r ? BASE : FIN;
                        end else begin
                            state_r <= XFER;
                        end
                    end else begin
                        write <= 1'b0;
                    end
                end
                BASE: begin
                    write      <= 1'b1;
                    write_reg  <= base_r;
                    write_data <= wb_data_r;
                    state_r    <= FIN;
                end
                FIN: begin
                    write   <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    write   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldm_writeback_seq.sv
// Scoreboard bench for ldm_writeback_seq: a driver enqueues the expected writes of each
// sequence from the register list; a negedge monitor pops and compares every DUT write.
`timescale 1ns/1ps
module tb_ldm_writeback_seq;

    logic        clk = 1'b0;
    logic        rst, start, wb_en, ld_valid;
    logic [15:0] reglist;
    logic [3:0]  base_reg;
    logic [31:0] wb_data, ld_data;
    logic        ld_ready, busy, done, write;
    logic [3:0]  write_reg;
    logic [31:0] write_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [36:0] exp_q[$];   // {is_base, reg, data}
    int exp_done = 0;
    bit pending_hs = 1'b0;

    ldm_writeback_seq dut (
        .clk(clk), .rst(rst), .start(start), .reglist(reglist), .base_reg(base_reg),
        .wb_en(wb_en), .wb_data(wb_data), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .busy(busy), .done(done), .write(write),
        .write_reg(write_reg), .write_data(write_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard queue.
    always @(negedge clk) begin
        logic [36:0] e;
        if (write === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("write_reg", 64'(write_reg), 64'(e[35:32]));
                check("write_data", 64'(write_data), 64'(e[31:0]));
                check("write_is_base", 64'(!pending_hs), 64'(e[36]));
            end
        end else if (pending_hs) begin
            check("hs_write_latency", 64'(write), 64'd1);
        end
        if (done === 1'b1) begin
            if (exp_done == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                exp_done--;
                check("done_all_written", 64'(exp_q.size()), 64'd0);
            end
        end
        pending_hs = ld_valid && ld_ready && !rst;
    end

    function automatic logic pick_valid(input bit use_pat, input logic [7:0] pat,
                                        input int cyc, input int pct);
        if (use_pat) return (cyc >= 1 && cyc <= 8) ? pat[cyc-1] : 1'b1;
        return ($urandom_range(0, 99) < pct);
    endfunction

    // Runs one full sequence starting at posedge+1 with the DUT idle.
    task automatic run_seq(input logic [15:0] rl, input logic [3:0] br, input logic wbe,
                           input logic [31:0] wbd, input bit use_pat,
                           input logic [7:0] pat, input int pct);
        logic [31:0] words[$];
        logic [31:0] w;
        int pc, k, cyc, last_hs;
        bit eff, hs, seen_done;
        eff = wbe && !rl[br];
        pc = 0;
        for (int n = 0; n < 16; n++) begin
            if (rl[n]) begin
                w = $urandom;
                words.push_back(w);
                exp_q.push_back({1'b0, 4'(n), w});
                pc++;
            end
        end
        if (eff) exp_q.push_back({1'b1, br, wbd});
        exp_done++;
        start = 1'b1; reglist = rl; base_reg = br; wb_en = wbe; wb_data = wbd;
        ld_valid = 1'b1; ld_data = $urandom;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; reglist = 16'($urandom); base_reg = 4'($urandom);
        wb_en = 1'($urandom); wb_data = $urandom;
        k = 0; cyc = 1; last_hs = 0; seen_done = 1'b0;
        ld_valid = pick_valid(use_pat, pat, cyc, pct);
        ld_data = (k < pc) ? words[k] : $urandom;
        while (!seen_done && cyc < 300) begin
            @(negedge clk);
            check("ld_ready", 64'(ld_ready), 64'(k < pc));
            check("busy", 64'(busy), 64'd1);
            hs = ld_valid && ld_ready;
            if (done) begin
                seen_done = 1'b1;
                check("done_cycle", 64'(cyc), 64'(last_hs + 1 + int'(eff)));
            end
            @(posedge clk); #1;
            if (hs) begin
                k++;
                last_hs = cyc;
            end
            cyc++;
            ld_valid = pick_valid(use_pat, pat, cyc, pct);
            ld_data = (k < pc) ? words[k] : $urandom;
        end
        if (!seen_done) check("done_timeout", 64'(seen_done), 64'd1);
        check("words_consumed", 64'(k), 64'(pc));
        ld_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1; start = 1'b1; reglist = 16'hFFFF; base_reg = 4'd0; wb_en = 1'b1;
        wb_data = 32'd0; ld_valid = 1'b1; ld_data = 32'd0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; start = 1'b0; ld_valid = 1'b0;
        @(negedge clk);
        check("rst_write", 64'(write), 64'd0);
        check("rst_write_reg", 64'(write_reg), 64'd0);
        check("rst_write_data", 64'(write_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ld_ready", 64'(ld_ready), 64'd0);
        @(posedge clk); #1;

        run_seq(16'h0005, 4'd0, 1'b0, 32'h0, 1'b0, 8'h00, 100);
        run_seq(16'h8001, 4'd3, 1'b1, 32'h0000_1000, 1'b0, 8'h00, 100);
        run_seq(16'h0009, 4'd3, 1'b1, 32'h0000_2222, 1'b0, 8'h00, 100);
        run_seq(16'h00F0, 4'd1, 1'b0, 32'h0, 1'b1, 8'h59, 100);
        run_seq(16'h0000, 4'd9, 1'b1, 32'hCAFE_F00D, 1'b0, 8'h00, 100);

        // Minimum sequence with start held through FIN and into IDLE.
        start = 1'b1; reglist = 16'h0000; wb_en = 1'b0; base_reg = 4'd0;
        exp_done += 2;
        @(negedge clk); check("min_c0_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("min_c1_done", 64'(done), 64'd1);
        check("min_c1_busy", 64'(busy), 64'd1);
        check("min_c1_write", 64'(write), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("min_c2_busy", 64'(busy), 64'd0);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); check("min_c3_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        @(negedge clk); check("min_c4_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Reset after two of four handshakes abandons the sequence.
        for (int n = 0; n < 4; n++) begin
            w = $urandom;
            exp_q.push_back({1'b0, 4'(n), w});
        end
        exp_done++;
        start = 1'b1; reglist = 16'h000F; wb_en = 1'b0;
        @(posedge clk); #1; start = 1'b0; ld_valid = 1'b1; ld_data = exp_q[0][31:0];
        @(posedge clk); #1; ld_data = exp_q[1][31:0];
        @(posedge clk); #1; rst = 1'b1; ld_data = exp_q[2][31:0];
        @(posedge clk); #1; rst = 1'b0; ld_valid = 1'b0;
        check("rst_mid_flushed", 64'(exp_q.size()), 64'd2);
        exp_q.delete();
        exp_done = 0;
        @(negedge clk);
        check("rst_mid_write", 64'(write), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_ld_ready", 64'(ld_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        run_seq(16'h000F, 4'd2, 1'b0, 32'h0, 1'b0, 8'h00, 100);

        for (int t = 0; t < 40; t++) begin
            logic [15:0] rl;
            rl = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            run_seq(rl, 4'($urandom), 1'($urandom), $urandom, 1'b0, 8'h00,
                    $urandom_range(30, 100));
        end

        repeat (3) @(posedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_done_count", 64'(exp_done), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
